load_hazard_scoreboard: RTL and testbench
=========================================

Name: load_hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use stall logic, for a pipeline whose data memory can have several loads outstanding and returns them in order after variable latency.
- Keeps a FIFO scoreboard of destination registers for issued, not-yet-returned loads.
- Stalls ID on a classic EX load-use hit, on any pending-load hit, or when the scoreboard cannot accept another load.
- Sits between the ID/EX pipeline registers and the writeback of load data.

Parameters:
- REG_W, 5, register-address width.
- DEPTH, 4, maximum outstanding loads (power of two, ≥2).
- STORE_FWD, 1, when 1 a store's rs2 (store data) never stalls, because data is forwarded at MEM; rs1 (address) always checks.
- RESP_BYPASS, 1, when 1 the head entry retiring this cycle does not cause a pending hit, because writeback data is forwarded to ID.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  squash the instruction in EX this cycle.
- ex_issue  in  1  EX instruction advances to MEM this cycle.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_W  EX destination register.
- id_mem_read  in  1  ID instruction is a load.
- id_mem_write  in  1  ID instruction is a store.
- id_rs1  in  REG_W  ID source 1.
- id_rs2  in  REG_W  ID source 2.
- id_valid_reg  in  3  bit1 = rs1 used, bit2 = rs2 used, bit0 unused here.
- ld_resp_valid  in  1  oldest outstanding load writes back this cycle.
- stall  out  1  hold PC and IF/ID, bubble into EX; combinational.
- queue_full  out  1  no load may issue this cycle; combinational.
- pending_count  out  $clog2(DEPTH)+1  registered occupancy.
- resp_err  out  1  sticky; set on a response with an empty scoreboard.

Behaviour:
- **Reset** (rst_n=0 at posedge): FIFO pointers = 0, pending_count = 0, resp_err = 0, all entry valids cleared. Reset mid-operation discards all pending entries; any later response is an error.
- **Push**: push = ex_issue & ex_mem_read & ~flush & ~queue_full. Writes ex_rd at the tail. rd = 0 is pushed so responses stay in order, but it never matches.
- **Pop**: pop = ld_resp_valid & (pending_count ≠ 0). Retires the head.
- **Simultaneous push and pop**: count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- **Response on empty**: no pop; resp_err ← 1 and holds until reset.
- **queue_full**: (pending_count == DEPTH) & ~ld_resp_valid. A pop in the same cycle frees a slot for a same-cycle push.
- **Source-match qualifier**, match(r), for a candidate register r:
  - r ≠ 0 AND
  - either (r == id_rs1 & id_valid_reg[1])
  - or (r == id_rs2 & id_valid_reg[2] & ~(STORE_FWD & id_mem_write)).
  - Precedence is explicit: the r ≠ 0 term gates both source terms.
- **load_use** = ex_mem_read & ~flush & match(ex_rd).
- **pending_hit**: OR over valid entries i of match(entry_rd[i]). When RESP_BYPASS=1, the head entry is excluded if ld_resp_valid this cycle.
- **full_stall** = id_mem_read & (count_next == DEPTH).
  - count_next = pending_count + push − pop.
  - This prevents a load entering EX with no slot.
- **stall** = load_use | pending_hit | full_stall. It depends only on current inputs and registered state; there is no extra latency.
- **Latency**: a pushed entry is visible to pending_hit from the cycle after the push. A popped entry disappears in the cycle after the pop, or in the same cycle via the bypass rule.
- **ID stalled**: a stalled ID instruction re-evaluates every cycle; no state is latched for it.

Test Plan:
- Reset, then EX lw x5 with ex_issue, and ID add using rs1=x5 → stall=1 that cycle. Next cycle the entry holds x5 and pending_count=1. With no response, stall stays 1. Assert ld_resp_valid → stall=0 that cycle with RESP_BYPASS=1, or the next cycle with RESP_BYPASS=0; count returns to 0.
- Issue 4 loads to x1..x4 with no response → pending_count=4, queue_full=1. ID lw with unrelated sources → stall=1 (full_stall). Assert ld_resp_valid while a fifth load issues → push accepted, count stays 4, head is now x2.
- ID sw with rs2=x7 while x7 is pending, STORE_FWD=1 → stall=0. Same with rs1=x7 → stall=1. Rerun with STORE_FWD=0 → stall=1 in both cases.
- EX load with ex_rd=0 and ID rs1=0 → stall=0, yet pending_count increments. The response pops it, and resp_err stays 0.
- flush asserted with an EX load to x9 matching ID rs2 → stall=0 and no push. A ld_resp_valid with an empty scoreboard → resp_err=1, sticky through 10 idle cycles, cleared only by rst_n=0.
- Wrap: 10 alternating push/pop pairs with DEPTH=4 → pointers wrap, and the head rd always equals the order in which loads were issued.

Source files
------------

// File: rtl/load_hazard_if.sv
// Hazard-unit bundle: ID/EX decode fields and load responses in, stall and scoreboard status out.
interface load_hazard_if #(
   parameter int REG_W = 5,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             ex_issue;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             id_mem_read;
   logic             id_mem_write;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [2:0]       id_valid_reg;
   logic             ld_resp_valid;
   logic             stall;
   logic             queue_full;
   logic [CNT_W-1:0] pending_count;
   logic             resp_err;

   modport master (
      output flush, ex_issue, ex_mem_read, ex_rd,
      output id_mem_read, id_mem_write, id_rs1, id_rs2, id_valid_reg,
      output ld_resp_valid,
      input  stall, queue_full, pending_count, resp_err
   );

   modport slave (
      input  flush, ex_issue, ex_mem_read, ex_rd,
      input  id_mem_read, id_mem_write, id_rs1, id_rs2, id_valid_reg,
      input  ld_resp_valid,
      output stall, queue_full, pending_count, resp_err
   );
endinterface

// File: rtl/load_hazard_scoreboard.sv
// Load-use stall logic with an in-order FIFO scoreboard of outstanding load destinations.
module load_hazard_scoreboard #(
   parameter int REG_W       = 5,
   parameter int DEPTH       = 4,
   parameter int STORE_FWD   = 1,
   parameter int RESP_BYPASS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   load_hazard_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_W-1:0] entry_rd [DEPTH];
   logic [DEPTH-1:0] entry_valid;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             resp_err;
   logic             queue_full;
   logic             push;
   logic             pop;
   logic             load_use;
   logic             pending_hit;
   logic             full_stall;
   logic             unused_valid0;

   assign unused_valid0 = bus.id_valid_reg[0];

   // Register zero gates both source terms; store data is exempt when forwarded at MEM.
   function automatic logic match(input logic [REG_W-1:0] r,
                                  input logic [REG_W-1:0] rs1,
                                  input logic [REG_W-1:0] rs2,
                                  input logic [2:0]       vr,
                                  input logic             mem_write);
      logic rs2_exempt;
      rs2_exempt = (STORE_FWD != 0) && mem_write;
      return (r != '0) &&
             (((r == rs1) && vr[1]) || ((r == rs2) && vr[2] && !rs2_exempt));
   endfunction

   assign queue_full = (count == CNT_W'(DEPTH)) && !bus.ld_resp_valid;
   assign push       = bus.ex_issue && bus.ex_mem_read && !bus.flush && !queue_full;
   assign pop        = bus.ld_resp_valid && (count != '0);
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   assign load_use   = bus.ex_mem_read && !bus.flush &&
                       match(bus.ex_rd, bus.id_rs1, bus.id_rs2, bus.id_valid_reg, bus.id_mem_write);
   assign full_stall = bus.id_mem_read && (count_next == CNT_W'(DEPTH));

   always_comb begin
      pending_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] &&
             !((RESP_BYPASS != 0) && bus.ld_resp_valid && (PTR_W'(i) == head)) &&
             match(entry_rd[i], bus.id_rs1, bus.id_rs2, bus.id_valid_reg, bus.id_mem_write)) begin
            pending_hit = 1'b1;
         end
      end
   end

   // On a full-queue push+pop head equals tail: the push set must win over the pop clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         resp_err    <= 1'b0;
         entry_valid <= '0;
      end else begin
         if (pop) begin
            entry_valid[head] <= 1'b0;
            head              <= head + PTR_W'(1);
         end
         if (push) begin
            entry_valid[tail] <= 1'b1;
            entry_rd[tail]    <= bus.ex_rd;
            tail              <= tail + PTR_W'(1);
         end
         count <= count_next;
         if (bus.ld_resp_valid && (count == '0)) begin
            resp_err <= 1'b1;
         end
      end
   end

   assign bus.stall         = load_use || pending_hit || full_stall;
   assign bus.queue_full    = queue_full;
   assign bus.pending_count = count;
   assign bus.resp_err      = resp_err;
endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Bench for load_hazard_scoreboard: directed scenarios plus randomized traffic against a queue model.
module tb_load_hazard_scoreboard;
   localparam int REG_W = 5;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush, ex_issue, ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             id_mem_read, id_mem_write;
   logic [REG_W-1:0] id_rs1, id_rs2;
   logic [2:0]       id_valid_reg;
   logic             ld_resp_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   int m_q[$];
   bit m_err;

   load_hazard_if #(.REG_W(REG_W), .DEPTH(DEPTH)) bus_a ();
   load_hazard_if #(.REG_W(REG_W), .DEPTH(DEPTH)) bus_b ();

   assign bus_a.flush = flush;          assign bus_b.flush = flush;
   assign bus_a.ex_issue = ex_issue;    assign bus_b.ex_issue = ex_issue;
   assign bus_a.ex_mem_read = ex_mem_read; assign bus_b.ex_mem_read = ex_mem_read;
   assign bus_a.ex_rd = ex_rd;          assign bus_b.ex_rd = ex_rd;
   assign bus_a.id_mem_read = id_mem_read; assign bus_b.id_mem_read = id_mem_read;
   assign bus_a.id_mem_write = id_mem_write; assign bus_b.id_mem_write = id_mem_write;
   assign bus_a.id_rs1 = id_rs1;        assign bus_b.id_rs1 = id_rs1;
   assign bus_a.id_rs2 = id_rs2;        assign bus_b.id_rs2 = id_rs2;
   assign bus_a.id_valid_reg = id_valid_reg; assign bus_b.id_valid_reg = id_valid_reg;
   assign bus_a.ld_resp_valid = ld_resp_valid; assign bus_b.ld_resp_valid = ld_resp_valid;

   // dut_a: store forwarding and response bypass on; dut_b: both off.
   load_hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .STORE_FWD(1), .RESP_BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   load_hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .STORE_FWD(0), .RESP_BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   always #5 clk = ~clk;

   function automatic bit m_match(int r, bit sf);
      return (r != 0) &&
             ((r == int'(id_rs1) && id_valid_reg[1]) ||
              (r == int'(id_rs2) && id_valid_reg[2] && !(sf && id_mem_write)));
   endfunction

   function automatic bit m_full();
      return (m_q.size() == DEPTH) && !ld_resp_valid;
   endfunction

   function automatic bit m_push();
      return ex_issue && ex_mem_read && !flush && !m_full();
   endfunction

   function automatic bit m_pop();
      return ld_resp_valid && (m_q.size() != 0);
   endfunction

   function automatic bit m_stall(bit sf, bit bp);
      bit hit;
      int next_size;
      hit = ex_mem_read && !flush && m_match(int'(ex_rd), sf);
      foreach (m_q[i]) begin
         if (!(bp && ld_resp_valid && i == 0) && m_match(m_q[i], sf)) hit = 1'b1;
      end
      next_size = m_q.size() + int'(m_push()) - int'(m_pop());
      if (id_mem_read && next_size == DEPTH) hit = 1'b1;
      return hit;
   endfunction

   task automatic step();
      bit p, o;
      int sz;
      p  = m_push();
      o  = m_pop();
      sz = m_q.size();
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_err = 1'b0;
      end else begin
         if (o) void'(m_q.pop_front());
         if (p) m_q.push_back(int'(ex_rd));
         if (ld_resp_valid && sz == 0) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      flush = 0; ex_issue = 0; ex_mem_read = 0; ex_rd = '0;
      id_mem_read = 0; id_mem_write = 0; id_rs1 = '0; id_rs2 = '0;
      id_valid_reg = '0; ld_resp_valid = 0;
   endtask

   task automatic issue_load(input logic [REG_W-1:0] rd);
      ex_issue = 1; ex_mem_read = 1; ex_rd = rd;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0) begin
         tests_failed++; $display("FAIL reset_count got %0d want 0", bus_a.pending_count);
      end
      tests_run++;
      if (bus_a.resp_err !== 1'b0 || bus_b.resp_err !== 1'b0) begin
         tests_failed++; $display("FAIL reset_err got %b/%b want 0", bus_a.resp_err, bus_b.resp_err);
      end
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_a.queue_full !== 1'b0) begin
         tests_failed++; $display("FAIL reset_outputs stall %b full %b want 0 0", bus_a.stall, bus_a.queue_full);
      end
   endtask

   task automatic test_load_use();
      idle();
      issue_load(5);
      id_rs1 = 5; id_valid_reg = 3'b010;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b1 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL load_use_ex got %b/%b want 1/1", bus_a.stall, bus_b.stall);
      end
      step();
      ex_issue = 0; ex_mem_read = 0; ex_rd = '0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 1) begin
         tests_failed++; $display("FAIL load_use_count got %0d want 1", bus_a.pending_count);
      end
      tests_run++;
      if (bus_a.stall !== 1'b1 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL load_use_pending got %b/%b want 1/1", bus_a.stall, bus_b.stall);
      end
      step();
      tests_run++;
      if (bus_a.stall !== 1'b1) begin
         tests_failed++; $display("FAIL load_use_hold got %b want 1", bus_a.stall);
      end
      ld_resp_valid = 1;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL load_use_bypass got %b/%b want 0/1", bus_a.stall, bus_b.stall);
      end
      step();
      ld_resp_valid = 0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0 || bus_b.stall !== 1'b0) begin
         tests_failed++; $display("FAIL load_use_retired count %0d stall_b %b want 0 0", bus_a.pending_count, bus_b.stall);
      end
   endtask

   task automatic test_full();
      idle();
      for (int r = 1; r <= 4; r++) begin
         issue_load(REG_W'(r));
         step();
      end
      idle();
      id_mem_read = 1; id_rs1 = 20; id_valid_reg = 3'b010;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 4 || bus_a.queue_full !== 1'b1) begin
         tests_failed++; $display("FAIL full_state count %0d full %b want 4 1", bus_a.pending_count, bus_a.queue_full);
      end
      tests_run++;
      if (bus_a.stall !== 1'b1 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL full_stall got %b/%b want 1/1", bus_a.stall, bus_b.stall);
      end
      ld_resp_valid = 1;
      issue_load(6);
      #1;
      tests_run++;
      if (bus_a.queue_full !== 1'b0 || bus_a.stall !== 1'b1) begin
         tests_failed++; $display("FAIL full_swap full %b stall %b want 0 1", bus_a.queue_full, bus_a.stall);
      end
      step();
      idle();
      id_rs1 = 1; id_valid_reg = 3'b010;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 4 || bus_a.stall !== 1'b0) begin
         tests_failed++; $display("FAIL full_after_swap count %0d stall %b want 4 0", bus_a.pending_count, bus_a.stall);
      end
      id_rs1 = 2; ld_resp_valid = 1;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL full_head_x2 got %b/%b want 0/1", bus_a.stall, bus_b.stall);
      end
      id_rs1 = 3;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b1) begin
         tests_failed++; $display("FAIL full_second_x3 got %b want 1", bus_a.stall);
      end
      id_valid_reg = '0;
      for (int i = 0; i < 4; i++) step();
      ld_resp_valid = 0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0 || bus_a.resp_err !== 1'b0) begin
         tests_failed++; $display("FAIL full_drain count %0d err %b want 0 0", bus_a.pending_count, bus_a.resp_err);
      end
   endtask

   task automatic test_store_fwd();
      idle();
      issue_load(7);
      step();
      idle();
      id_mem_write = 1; id_rs1 = 10; id_rs2 = 7; id_valid_reg = 3'b110;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL store_rs2 got %b/%b want 0/1", bus_a.stall, bus_b.stall);
      end
      id_rs1 = 7; id_rs2 = 11;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b1 || bus_b.stall !== 1'b1) begin
         tests_failed++; $display("FAIL store_rs1 got %b/%b want 1/1", bus_a.stall, bus_b.stall);
      end
      idle();
      ld_resp_valid = 1;
      step();
      ld_resp_valid = 0;
   endtask

   task automatic test_rd_zero();
      idle();
      issue_load(0);
      id_rs1 = 0; id_valid_reg = 3'b010;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b0) begin
         tests_failed++; $display("FAIL rd_zero_ex got %b/%b want 0/0", bus_a.stall, bus_b.stall);
      end
      step();
      ex_issue = 0; ex_mem_read = 0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 1 || bus_b.stall !== 1'b0) begin
         tests_failed++; $display("FAIL rd_zero_pending count %0d stall_b %b want 1 0", bus_a.pending_count, bus_b.stall);
      end
      ld_resp_valid = 1;
      step();
      ld_resp_valid = 0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0 || bus_a.resp_err !== 1'b0) begin
         tests_failed++; $display("FAIL rd_zero_pop count %0d err %b want 0 0", bus_a.pending_count, bus_a.resp_err);
      end
   endtask

   task automatic test_flush_err();
      int bad;
      idle();
      flush = 1;
      issue_load(9);
      id_rs2 = 9; id_valid_reg = 3'b100;
      #1;
      tests_run++;
      if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b0) begin
         tests_failed++; $display("FAIL flush_stall got %b/%b want 0/0", bus_a.stall, bus_b.stall);
      end
      step();
      idle();
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0) begin
         tests_failed++; $display("FAIL flush_no_push count %0d want 0", bus_a.pending_count);
      end
      ld_resp_valid = 1;
      step();
      ld_resp_valid = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_a.resp_err !== 1'b1 || bus_b.resp_err !== 1'b1 || bus_a.pending_count !== 0) bad++;
         step();
      end
      tests_run++;
      if (bad != 0 || bus_a.resp_err !== 1'b1) begin
         tests_failed++; $display("FAIL err_sticky bad_cycles %0d err %b want 0 1", bad, bus_a.resp_err);
      end
      do_reset();
      tests_run++;
      if (bus_a.resp_err !== 1'b0 || bus_b.resp_err !== 1'b0) begin
         tests_failed++; $display("FAIL err_clear got %b/%b want 0/0", bus_a.resp_err, bus_b.resp_err);
      end
   endtask

   task automatic test_wrap();
      int bad;
      idle();
      issue_load(11);
      step();
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         issue_load(REG_W'(12 + k));
         ld_resp_valid = 1;
         id_rs1 = REG_W'(11 + k); id_valid_reg = 3'b010;
         #1;
         if (bus_a.stall !== 1'b0 || bus_b.stall !== 1'b1) begin
            bad++;
            $display("FAIL wrap_head iter %0d stall %b/%b want 0/1", k, bus_a.stall, bus_b.stall);
         end
         step();
         if (bus_a.pending_count !== 1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL wrap_order bad %0d want 0", bad);
      end
      idle();
      ld_resp_valid = 1;
      step();
      ld_resp_valid = 0;
      #1;
      tests_run++;
      if (bus_a.pending_count !== 0 || bus_a.resp_err !== 1'b0) begin
         tests_failed++; $display("FAIL wrap_drain count %0d err %b want 0 0", bus_a.pending_count, bus_a.resp_err);
      end
   endtask

   task automatic test_random();
      int bad;
      bit ea, eb, ef;
      bad = 0;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         rst_n         = ($urandom_range(0, 79) != 0);
         flush         = ($urandom_range(0, 7) == 0);
         ex_issue      = ($urandom_range(0, 3) != 0);
         ex_mem_read   = ($urandom_range(0, 2) != 0);
         ex_rd         = REG_W'($urandom_range(0, 7));
         id_mem_read   = ($urandom_range(0, 2) == 0);
         id_mem_write  = !id_mem_read && ($urandom_range(0, 2) == 0);
         id_rs1        = REG_W'($urandom_range(0, 7));
         id_rs2        = REG_W'($urandom_range(0, 7));
         id_valid_reg  = 3'($urandom_range(0, 7));
         ld_resp_valid = ($urandom_range(0, 2) == 0);
         #1;
         ea = m_stall(1'b1, 1'b1);
         eb = m_stall(1'b0, 1'b0);
         ef = m_full();
         if (bus_a.stall !== ea || bus_b.stall !== eb || bus_a.queue_full !== ef ||
             bus_a.pending_count !== m_q.size() || bus_a.resp_err !== m_err ||
             bus_b.resp_err !== m_err) begin
            if (bad < 5)
               $display("FAIL random cycle %0d stall %b/%b full %b cnt %0d err %b want %b/%b %b %0d %b",
                        n, bus_a.stall, bus_b.stall, bus_a.queue_full, bus_a.pending_count,
                        bus_a.resp_err, ea, eb, ef, m_q.size(), m_err);
            bad++;
         end
         step();
      end
      rst_n = 1;
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL random_total mismatching_cycles %0d want 0", bad);
      end
   endtask

   initial begin
      m_err = 1'b0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_full();
      test_store_fwd();
      test_rd_zero();
      test_flush_err();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
